counter_sequencer: RTL and testbench

COUNTER_SEQUENCER -- requirements
Module: counter_sequencer

---
 rtl/counter_seq_pkg.sv | 41 ++++
 rtl/step_prescaler.sv | 37 +++
 rtl/counter_sequencer.sv | 141 ++++++++++++++
 tb/tb_counter_sequencer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_seq_pkg.sv
// Shared types for the counter sequencer: FSM states, run modes, command codes
// and the width of the counter value fed back from the driven counter.
package counter_seq_pkg;

  localparam int DATA_W = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_RUN,
    ST_PAUSED,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    MODE_DEC = 2'b00,
    MODE_SHR = 2'b01,
    MODE_SHL = 2'b10,
    MODE_ALT = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    CMD_NONE,
    CMD_DCRM,
    CMD_SHR,
    CMD_SHL
  } cmd_e;

  // Alternate mode decrements on even steps and shifts left on odd steps.
  function automatic cmd_e mode_cmd(input mode_e m, input logic odd);
    cmd_e c;
    case (m)
      MODE_DEC: c = CMD_DCRM;
      MODE_SHR: c = CMD_SHR;
      MODE_SHL: c = CMD_SHL;
      default:  c = odd ? CMD_SHL : CMD_DCRM;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/step_prescaler.sv
// Free-running 0..STEP_DIV-1 prescaler with synchronous clear and freeze.
// tick is high during the enabled terminal-count cycle.
module step_prescaler #(
  parameter int STEP_DIV = 25_000_000
) (
  input  logic o_clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(STEP_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    tick  = en && (cnt_q == TERM);
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge o_clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/counter_sequencer.sv
// Issues timed set/decrement/shift commands to an external 12-bit counter,
// with pause/resume, abort, a step limit and a guard against decrementing zero.
module counter_sequencer
  import counter_seq_pkg::*;
#(
  parameter int STEP_DIV  = 25_000_000,
  parameter int MAX_STEPS = 255
) (
  input  logic              o_clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              pause_tgl,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] data,
  output logic              set,
  output logic              dcrm,
  output logic              shift_right1,
  output logic              shift_left2,
  output logic              input_pause,
  output logic              busy,
  output logic              done,
  output logic [7:0]        step_count,
  output state_e            state_dbg
);

  localparam logic [7:0] MAX_CNT = 8'(MAX_STEPS);

  state_e     state_q, state_d;
  mode_e      mode_q, mode_d;
  logic [7:0] step_count_q, step_count_d;
  logic       set_q, set_d, dcrm_q, dcrm_d;
  logic       shr_q, shr_d, shl_q, shl_d;
  logic       input_pause_q, input_pause_d;
  logic       busy_q, busy_d, done_q, done_d;
  cmd_e       cmd;
  logic       idle_like, at_max, pre_en, pre_clr, tick;

  // The prescaler already counts during INIT so the first command lands
  // exactly STEP_DIV cycles after the set pulse.
  always_comb begin
    idle_like = (state_q == ST_IDLE) || (state_q == ST_DONE);
    at_max    = (step_count_q == MAX_CNT);
    pre_clr   = abort || (idle_like && start);
    pre_en    = !abort && ((state_q == ST_INIT) ||
                           ((state_q == ST_RUN) && !pause_tgl && !at_max));
  end

  step_prescaler #(.STEP_DIV(STEP_DIV)) u_prescaler (
    .o_clk (o_clk),
    .reset (reset),
    .en    (pre_en),
    .clr   (pre_clr),
    .tick  (tick)
  );

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    step_count_d = step_count_q;
    cmd          = CMD_NONE;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_d      = ST_INIT;
            mode_d       = mode_e'(mode);
            step_count_d = '0;
          end
        end
        ST_INIT: state_d = ST_RUN;
        ST_RUN: begin
          if (at_max) begin
            state_d = ST_DONE;
          end else if (pause_tgl) begin
            state_d = ST_PAUSED;
          end else if (tick) begin
            cmd = mode_cmd(mode_q, step_count_q[0]);
            // Refuse to decrement a zero counter so it never wraps.
            if ((cmd == CMD_DCRM) && (data == '0)) begin
              cmd     = CMD_NONE;
              state_d = ST_DONE;
            end else begin
              step_count_d = step_count_q + 8'd1;
            end
          end
        end
        ST_PAUSED: if (pause_tgl) state_d = ST_RUN;
        default:   state_d = ST_IDLE;
      endcase
    end
    set_d         = (state_d == ST_INIT);
    dcrm_d        = (cmd == CMD_DCRM);
    shr_d         = (cmd == CMD_SHR);
    shl_d         = (cmd == CMD_SHL);
    input_pause_d = (state_d == ST_IDLE) || (state_d == ST_PAUSED) ||
                    (state_d == ST_DONE);
    busy_d        = (state_d == ST_INIT) || (state_d == ST_RUN) ||
                    (state_d == ST_PAUSED);
    done_d        = (state_d == ST_DONE);
  end

  always_ff @(posedge o_clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      mode_q        <= MODE_DEC;
      step_count_q  <= '0;
      set_q         <= 1'b0;
      dcrm_q        <= 1'b0;
      shr_q         <= 1'b0;
      shl_q         <= 1'b0;
      input_pause_q <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      step_count_q  <= step_count_d;
      set_q         <= set_d;
      dcrm_q        <= dcrm_d;
      shr_q         <= shr_d;
      shl_q         <= shl_d;
      input_pause_q <= input_pause_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign set          = set_q;
  assign dcrm         = dcrm_q;
  assign shift_right1 = shr_q;
  assign shift_left2  = shl_q;
  assign input_pause  = input_pause_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign step_count   = step_count_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer: a per-cycle vector table on a
// STEP_DIV=4/MAX_STEPS=3 instance plus hand-written multi-cycle sequences.
module tb_counter_sequencer;
  import counter_seq_pkg::*;

  // Flag order: {set, dcrm, shift_right1, shift_left2, input_pause, busy, done}
  localparam logic [6:0] F_IDLE = 7'b0000100;
  localparam logic [6:0] F_INIT = 7'b1000010;
  localparam logic [6:0] F_RUN  = 7'b0000010;
  localparam logic [6:0] F_DCRM = 7'b0100010;
  localparam logic [6:0] F_SHR  = 7'b0010010;
  localparam logic [6:0] F_SHL  = 7'b0001010;
  localparam logic [6:0] F_PAUS = 7'b0000110;
  localparam logic [6:0] F_DONE = 7'b0000101;

  typedef struct {
    logic       start;
    logic       abort;
    logic       ptgl;
    logic [1:0] mode;
    logic [6:0] exp_flags;
    logic [7:0] exp_step;
  } vec_t;

  logic        o_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, abort = 1'b0, pause_tgl = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [11:0] data = 12'd0;

  logic set_a, dcrm_a, shr_a, shl_a, ip_a, busy_a, done_a;
  logic set_b, dcrm_b, shr_b, shl_b, ip_b, busy_b, done_b;
  logic [7:0] step_a, step_b;
  state_e st_a, st_b;

  int checks = 0;
  int errors = 0;
  int onehot_err = 0;
  int pulses_a = 0;

  always #5 o_clk = ~o_clk;

  counter_sequencer #(.STEP_DIV(4), .MAX_STEPS(3)) dut_a (
    .o_clk(o_clk), .reset(rst_n), .start(start), .abort(abort),
    .pause_tgl(pause_tgl), .mode(mode), .data(data),
    .set(set_a), .dcrm(dcrm_a), .shift_right1(shr_a), .shift_left2(shl_a),
    .input_pause(ip_a), .busy(busy_a), .done(done_a),
    .step_count(step_a), .state_dbg(st_a)
  );

  counter_sequencer #(.STEP_DIV(4), .MAX_STEPS(4)) dut_b (
    .o_clk(o_clk), .reset(rst_n), .start(start), .abort(abort),
    .pause_tgl(pause_tgl), .mode(mode), .data(data),
    .set(set_b), .dcrm(dcrm_b), .shift_right1(shr_b), .shift_left2(shl_b),
    .input_pause(ip_b), .busy(busy_b), .done(done_b),
    .step_count(step_b), .state_dbg(st_b)
  );

  function automatic logic [6:0] flags_a();
    return {set_a, dcrm_a, shr_a, shl_a, ip_a, busy_a, done_a};
  endfunction

  function automatic logic [1:0] cmd_code(input logic d, input logic r, input logic l);
    if (d) return 2'd1;
    if (r) return 2'd2;
    if (l) return 2'd3;
    return 2'd0;
  endfunction

  function automatic vec_t mk(input logic s, input logic a, input logic p,
                              input logic [1:0] m, input logic [6:0] f,
                              input logic [7:0] st);
    vec_t v;
    v.start = s; v.abort = a; v.ptgl = p; v.mode = m;
    v.exp_flags = f; v.exp_step = st;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic clk1();
    @(posedge o_clk);
    #1;
    if ($countones({set_a, dcrm_a, shr_a, shl_a}) > 1) onehot_err++;
    if ($countones({set_b, dcrm_b, shr_b, shl_b}) > 1) onehot_err++;
    if (dcrm_a || shr_a || shl_a) pulses_a++;
  endtask

  task automatic clks(input int n);
    for (int i = 0; i < n; i++) clk1();
  endtask

  task automatic check_a(input string name, input logic [6:0] f, input logic [7:0] st);
    check({name, " flags"}, 32'(flags_a()), 32'(f));
    check({name, " step"}, 32'(step_a), 32'(st));
  endtask

  vec_t vecs[27];
  logic [1:0] exp_q[$];
  logic [1:0] code;
  int p0;
  int bad;

  initial begin
    // Mode 10 run to MAX_STEPS, restart in mode 01, abort on a tick.
    vecs[0]  = mk(1, 0, 0, 2'b10, F_INIT, 8'd0);
    vecs[1]  = mk(0, 0, 1, 2'b00, F_RUN,  8'd0);
    vecs[2]  = mk(0, 0, 0, 2'b00, F_RUN,  8'd0);
    vecs[3]  = mk(0, 0, 0, 2'b00, F_RUN,  8'd0);
    vecs[4]  = mk(0, 0, 0, 2'b00, F_SHL,  8'd1);
    vecs[5]  = mk(0, 0, 0, 2'b00, F_RUN,  8'd1);
    vecs[6]  = mk(0, 0, 0, 2'b00, F_RUN,  8'd1);
    vecs[7]  = mk(0, 0, 0, 2'b00, F_RUN,  8'd1);
    vecs[8]  = mk(0, 0, 0, 2'b00, F_SHL,  8'd2);
    vecs[9]  = mk(0, 0, 0, 2'b00, F_RUN,  8'd2);
    vecs[10] = mk(0, 0, 0, 2'b00, F_RUN,  8'd2);
    vecs[11] = mk(0, 0, 0, 2'b00, F_RUN,  8'd2);
    vecs[12] = mk(0, 0, 0, 2'b00, F_SHL,  8'd3);
    vecs[13] = mk(0, 0, 0, 2'b00, F_DONE, 8'd3);
    vecs[14] = mk(0, 0, 1, 2'b00, F_DONE, 8'd3);
    vecs[15] = mk(1, 0, 0, 2'b01, F_INIT, 8'd0);
    vecs[16] = mk(1, 0, 0, 2'b01, F_RUN,  8'd0);
    vecs[17] = mk(1, 0, 0, 2'b01, F_RUN,  8'd0);
    vecs[18] = mk(0, 0, 0, 2'b01, F_RUN,  8'd0);
    vecs[19] = mk(0, 0, 0, 2'b01, F_SHR,  8'd1);
    vecs[20] = mk(0, 0, 0, 2'b01, F_RUN,  8'd1);
    vecs[21] = mk(0, 0, 0, 2'b01, F_RUN,  8'd1);
    vecs[22] = mk(0, 0, 0, 2'b01, F_RUN,  8'd1);
    vecs[23] = mk(0, 1, 1, 2'b01, F_IDLE, 8'd1);
    vecs[24] = mk(0, 0, 0, 2'b01, F_IDLE, 8'd1);
    vecs[25] = mk(0, 0, 1, 2'b01, F_IDLE, 8'd1);
    vecs[26] = mk(1, 1, 0, 2'b01, F_IDLE, 8'd1);

    // Reset values, then idle until start.
    clks(3);
    check_a("reset", F_IDLE, 8'd0);
    check("reset state", 32'(st_a), 32'(ST_IDLE));
    rst_n = 1'b1;
    clks(2);
    check_a("idle after reset", F_IDLE, 8'd0);

    // data stays 0 here: shift modes must not be guarded.
    for (int i = 0; i < 27; i++) begin
      start = vecs[i].start; abort = vecs[i].abort;
      pause_tgl = vecs[i].ptgl; mode = vecs[i].mode;
      clk1();
      check_a($sformatf("vec%0d", i), vecs[i].exp_flags, vecs[i].exp_step);
    end
    start = 0; abort = 0; pause_tgl = 0;

    // Decrement guard: data 2,1,0 at successive ticks.
    p0 = pulses_a;
    mode = 2'b00; data = 12'd2; start = 1;
    clk1();
    start = 0;
    check_a("dec init", F_INIT, 8'd0);
    clks(3); clk1();
    check_a("dec tick1", F_DCRM, 8'd1);
    data = 12'd1;
    clks(3); clk1();
    check_a("dec tick2", F_DCRM, 8'd2);
    data = 12'd0;
    clks(3); clk1();
    check_a("dec guard", F_DONE, 8'd2);
    check("dec pulse total", 32'(pulses_a - p0), 32'd2);

    // Alternate mode on the MAX_STEPS=4 instance.
    exp_q = '{2'd1, 2'd3, 2'd1, 2'd3};
    mode = 2'b11; data = 12'd5; start = 1;
    clk1();
    start = 0;
    for (int c = 0; c < 60 && !done_b; c++) begin
      clk1();
      code = cmd_code(dcrm_b, shr_b, shl_b);
      if (code != 2'd0) begin
        if (exp_q.size() == 0) check("alt extra cmd", 32'(code), 32'd0);
        else check("alt cmd", 32'(code), 32'(exp_q.pop_front()));
      end
    end
    check("alt done reached", 32'(done_b), 32'd1);
    check("alt cmds remaining", 32'(exp_q.size()), 32'd0);
    check("alt step", 32'(step_b), 32'd4);

    // Pause on the tick cycle, stay paused 10 cycles, resume.
    mode = 2'b10; data = 12'd5; start = 1;
    clk1();
    start = 0;
    clks(3);
    check_a("pause pre", F_RUN, 8'd0);
    pause_tgl = 1;
    clk1();
    pause_tgl = 0;
    check_a("pause enter", F_PAUS, 8'd0);
    check("pause state", 32'(st_a), 32'(ST_PAUSED));
    bad = 0;
    for (int c = 0; c < 9; c++) begin
      clk1();
      if (!ip_a || dcrm_a || shr_a || shl_a || st_a != ST_PAUSED) bad++;
    end
    check("pause hold cycles", 32'(bad), 32'd0);
    pause_tgl = 1;
    clk1();
    pause_tgl = 0;
    check_a("resume", F_RUN, 8'd0);
    clk1();
    check_a("resume cmd", F_SHL, 8'd1);
    clks(3); clk1();
    check_a("resume next cmd", F_SHL, 8'd2);

    // Asynchronous reset between edges, then a fresh run.
    clks(2);
    #3;
    rst_n = 1'b0;
    #1;
    check_a("async reset", F_IDLE, 8'd0);
    check("async reset state", 32'(st_a), 32'(ST_IDLE));
    check("async reset b", 32'({busy_b, ip_b, step_b}), 32'({1'b0, 1'b1, 8'd0}));
    clk1();
    rst_n = 1'b1;
    clk1();
    check_a("post reset idle", F_IDLE, 8'd0);
    start = 1;
    clk1();
    start = 0;
    check_a("restart init", F_INIT, 8'd0);
    clks(3); clk1();
    check_a("restart cmd", F_SHL, 8'd1);

    check("command onehot", 32'(onehot_err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
